// File: rtl/mips_mdu.sv
// Multi-cycle MIPS multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, sign correction in FIX, results held in HI/LO.
module mips_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   ZERO_W1  = {(WIDTH + 1){1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               is_div_r;
  logic               a_neg_r;
  logic               b_neg_r;
  logic               b_zero_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH:0]   acc_r;

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     upper_s;
  logic [2*WIDTH:0]   shl_s;
  logic [2*WIDTH:0]   step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;

  // Operand magnitudes and signs; op[0]=1 selects the unsigned variants.
  always_comb begin
    a_neg_s = ~op[0] & src_a[WIDTH-1];
    b_neg_s = ~op[0] & src_b[WIDTH-1];
    a_mag_s = a_neg_s ? (ZERO_W - src_a) : src_a;
    b_mag_s = b_neg_s ? (ZERO_W - src_b) : src_b;
  end

  // One iteration: multiply adds into the upper half then shifts right,
  // divide shifts left and subtracts the divisor when it fits.
  always_comb begin
    upper_s = acc_r[2*WIDTH:WIDTH];
    shl_s   = {acc_r[2*WIDTH-1:0], 1'b0};
    step_s  = acc_r;
    if (is_div_r) begin
      if (shl_s[2*WIDTH:WIDTH] >= {1'b0, opnd_r}) begin
        step_s = {shl_s[2*WIDTH:WIDTH] - {1'b0, opnd_r}, shl_s[WIDTH-1:1], 1'b1};
      end else begin
        step_s = shl_s;
      end
    end else begin
      if (acc_r[0]) begin
        upper_s = acc_r[2*WIDTH:WIDTH] + {1'b0, opnd_r};
      end else begin
        upper_s = acc_r[2*WIDTH:WIDTH];
      end
      step_s = {1'b0, upper_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction; a zero divisor leaves remainder = |a| and forces quotient to all ones.
  always_comb begin
    prod_s   = (a_neg_r ^ b_neg_r) ? ({(2*WIDTH){1'b0}} - acc_r[2*WIDTH-1:0])
                                   : acc_r[2*WIDTH-1:0];
    res_hi_s = prod_s[2*WIDTH-1:WIDTH];
    res_lo_s = prod_s[WIDTH-1:0];
    if (is_div_r) begin
      res_hi_s = a_neg_r ? (ZERO_W - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
      if (b_zero_r) begin
        res_lo_s = ONES_W;
      end else begin
        res_lo_s = (a_neg_r ^ b_neg_r) ? (ZERO_W - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
      end
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, datapath registers and HI/LO with their status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      is_div_r    <= 1'b0;
      a_neg_r     <= 1'b0;
      b_neg_r     <= 1'b0;
      b_zero_r    <= 1'b0;
      opnd_r      <= ZERO_W;
      acc_r       <= {ZERO_W1, ZERO_W};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= ZERO_W;
      lo          <= ZERO_W;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          if (start) begin
            state_r  <= CALC;
            busy     <= 1'b1;
            cnt_r    <= CNT_ZERO;
            is_div_r <= op[1];
            a_neg_r  <= a_neg_s;
            b_neg_r  <= b_neg_s;
            b_zero_r <= (src_b == ZERO_W);
            opnd_r   <= op[1] ? b_mag_s : a_mag_s;
            acc_r    <= {ZERO_W1, (op[1] ? a_mag_s : b_mag_s)};
          end else begin
            state_r <= IDLE;
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) state_r <= FIX;
        end
        FIX: begin
          hi          <= res_hi_s;
          lo          <= res_lo_s;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= is_div_r & b_zero_r;
          state_r     <= DONE;
        end
        default: begin
          state_r     <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          div_by_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mdu.sv
// Directed bench for mips_mdu: vector table for WIDTH=32, hand sequences for
// HI/LO writes, start-while-busy, mid-operation reset and a WIDTH=8 instance.
module tb_mips_mdu;

  logic        clk;
  logic        rst;
  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  logic        start8, hi_we8, lo_we8;
  logic [1:0]  op8;
  logic [7:0]  src_a8, src_b8, wdata8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int checks;
  int errors;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
  } vec_t;

  vec_t vecs[12];

  mips_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  mips_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .src_a(src_a8), .src_b(src_b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation at a negedge (cycle 0) and follow it to its done pulse.
  task automatic do_op(input bit sel, input string name, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    int  cyc;
    bit  seen;
    bit  busy_ok;
    int  exp_lat;
    exp_lat = sel ? 10 : 34;
    if (sel) begin
      start8 = 1'b1; op8 = o; src_a8 = a[7:0]; src_b8 = b[7:0];
    end else begin
      start = 1'b1; op = o; src_a = a; src_b = b;
    end
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    cyc = 1; seen = 1'b0; busy_ok = 1'b1;
    while (cyc < 60 && !seen) begin
      if (sel ? done8 : done) begin
        seen = 1'b1;
      end else begin
        if ((sel ? busy8 : busy) !== 1'b1 || (sel ? dbz8 : div_by_zero) !== 1'b0) busy_ok = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({name, "_busy_profile"}, 64'(busy_ok), 64'd1);
    check({name, "_busy_at_done"}, 64'(sel ? busy8 : busy), 64'd0);
    check({name, "_dbz"}, 64'(sel ? dbz8 : div_by_zero), 64'(edbz));
    check({name, "_hi"}, sel ? 64'(hi8) : 64'(hi), 64'(sel ? {24'd0, ehi[7:0]} : ehi));
    check({name, "_lo"}, sel ? 64'(lo8) : 64'(lo), 64'(sel ? {24'd0, elo[7:0]} : elo));
  endtask

  initial begin
    int  done_cyc;
    bit  done_seen;
    logic [31:0] hi_cap, lo_cap;

    checks = 0; errors = 0;
    clk = 1'b0; rst = 1'b0;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'd0;
    src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
    start8 = 1'b0; hi_we8 = 1'b0; lo_we8 = 1'b0; op8 = 2'd0;
    src_a8 = 8'd0; src_b8 = 8'd0; wdata8 = 8'd0;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{2'b11, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0};
    vecs[6]  = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[7]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[11] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    // Reset with inputs active: they must be ignored.
    start = 1'b1; hi_we = 1'b1; wdata = 32'h5555_5555;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    start = 1'b0; hi_we = 1'b0; rst = 1'b1;
    @(negedge clk);

    // MTHI / MTLO / both.
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    check("mthi_lo", 64'(lo), 64'd0);
    lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mtboth_hi", 64'(hi), 64'hCAFE_F00D);
    check("mtboth_lo", 64'(lo), 64'hCAFE_F00D);

    // start beats a same-cycle write; writes while busy are dropped.
    start = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd3; hi_we = 1'b1; wdata = 32'd0;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("start_wins_hi", 64'(hi), 64'hCAFE_F00D);
    check("start_wins_busy", 64'(busy), 64'd1);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'd0;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("busy_write_hi", 64'(hi), 64'hCAFE_F00D);
    check("busy_write_lo", 64'(lo), 64'hCAFE_F00D);
    done_seen = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("mul23_done", 64'(done_seen), 64'd1);
    check("mul23_hi", 64'(hi), 64'd0);
    check("mul23_lo", 64'(lo), 64'd6);

    for (int i = 0; i < 12; i++) begin
      do_op(1'b0, $sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].ehi, vecs[i].elo, vecs[i].edbz);
    end
    @(negedge clk);
    check("dbz_after_done", 64'(div_by_zero), 64'd0);

    // Run 1: a start and hi_we in cycle 5 must not disturb MULTU 3*4.
    start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
    done_cyc = -1; hi_cap = 32'hXXXX_XXXX; lo_cap = 32'hXXXX_XXXX;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      if (c == 5) begin
        start = 1'b1; src_a = 32'd5; src_b = 32'd6; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (done && done_cyc < 0) begin
        done_cyc = c; hi_cap = hi; lo_cap = lo;
      end
    end
    check("run1_done_cycle", 64'(done_cyc), 64'd34);
    check("run1_hi", 64'(hi_cap), 64'd0);
    check("run1_lo", 64'(lo_cap), 64'd12);

    // Run 2: reset in cycle 10 aborts the operation.
    start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
    done_seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) done_seen = 1'b1;
      if (c == 10) begin
        rst = 1'b0; start = 1'b1; hi_we = 1'b1; wdata = 32'hFFFF_FFFF;
      end
      if (c == 11) begin
        check("run2_busy_in_rst", 64'(busy), 64'd0);
        rst = 1'b1; start = 1'b0; hi_we = 1'b0;
      end
    end
    check("run2_no_done", 64'(done_seen), 64'd0);
    check("run2_busy", 64'(busy), 64'd0);
    check("run2_hi", 64'(hi), 64'd0);
    check("run2_lo", 64'(lo), 64'd0);

    // WIDTH=8 instance.
    do_op(1'b1, "w8_div", 2'b10, 32'h81, 32'h03, 32'hFF, 32'hD6, 1'b0);
    do_op(1'b1, "w8_multu", 2'b01, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0);
    do_op(1'b1, "w8_mult", 2'b00, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0);
    do_op(1'b1, "w8_divu0", 2'b11, 32'h80, 32'h00, 32'h80, 32'hFF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
